mem_arbiter_rr: RTL and testbench
=================================

Name: mem_arbiter_rr

Overview:
- Parametrised successor to the single-CPU memory controller: arbitrates instruction and data requests from CPUS cores onto one shared RAM port.
- Round-robin fairness across cores; data-before-instruction priority within a core.
- Registered grant held for the whole RAM transaction.
- Sits between the per-core cache_control interfaces and the RAM model.

Parameters:
- CPUS, 2, number of cores (1..8).
- AW, 32, address width.
- DW, 32, data word width.
- TIMEOUT, 64, cycles a grant may wait for ACCESS (only with MEM_ARB_TIMEOUT_EN).

Ports:
- CLK  in  1  clock.
- nRST  in  1  synchronous active-low reset, sampled on CLK rising edge.
- iREN  in  CPUS  instruction read request per core.
- dREN  in  CPUS  data read request per core.
- dWEN  in  CPUS  data write request per core.
- iaddr  in  CPUS*AW  instruction address, core n at [n*AW +: AW].
- daddr  in  CPUS*AW  data address, same packing.
- dstore  in  CPUS*DW  write data, same packing.
- iwait  out  CPUS  instruction stall per core.
- dwait  out  CPUS  data stall per core.
- iload  out  DW  read data (broadcast).
- dload  out  DW  read data (broadcast).
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  AW  RAM address.
- ramstore  out  DW  RAM write data.
- ramload  in  DW  RAM read data.
- ramstate  in  2  RAM state: FREE, BUSY, ACCESS, ERROR (cpu_types_pkg ramstate_t).
- arb_err  out  1  one-cycle timeout pulse (tied 0 without macro).

Behaviour:
- Sources:
  - Core n has source D (dREN|dWEN) and source I (iREN).
  - Core request = D | I.
  - Selected source of a core is D if D requested, else I.
- State machine: IDLE, GRANT, DONE.
- IDLE:
  - If any core requests, pick the first requesting core scanning from rr_ptr upward, modulo CPUS.
  - Register gnt_cpu and gnt_is_d; go GRANT next cycle.
  - No requests: stay in IDLE.
- GRANT:
  - ramaddr = daddr/iaddr of granted source.
  - ramREN = dREN or iREN of granted source.
  - ramWEN = dWEN of granted source.
  - ramstore = granted core's dstore.
  - dWEN and dREN both set on one core: write wins, ramREN=0.
  - ramstate==ACCESS: deassert the granted wait (dwait or iwait of gnt_cpu) combinationally in that same cycle; go DONE.
  - ramstate FREE, BUSY or ERROR: hold the grant and keep all waits at 1.
  - Granted request drops before ACCESS: abort to IDLE next cycle, rr_ptr unchanged, no ack.
- DONE:
  - RAM enables = 0, all waits = 1.
  - rr_ptr = gnt_cpu+1 mod CPUS.
  - Go IDLE. This gives one bubble cycle between transactions so the RAM returns to FREE.
- Request changes: changes on non-granted cores never affect an in-flight grant. A core switching D to I mid-grant does not re-select; the grant follows the registered gnt_is_d, and the drop rule applies.
- Waits and data:
  - Every wait bit not acknowledged in the current cycle is 1.
  - At most one wait bit is 0 per cycle.
  - iload = dload = ramload at all times.
- Reset (nRST low at CLK edge, including mid-transaction):
  - State IDLE, rr_ptr 0, gnt_cpu 0, gnt_is_d 0, timeout counter 0.
  - Outputs next cycle: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, all iwait/dwait=1, arb_err=0.
- CPUS=1 degenerates to the single-core priority behaviour, plus one grant cycle and one DONE cycle.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- With the macro:
  - Counter clears on entry to GRANT and increments each GRANT cycle without ACCESS.
  - At count TIMEOUT-1 without ACCESS: arb_err pulses 1 for one cycle, RAM enables drop, the granted wait is released with data invalid, and the state goes to DONE (rr_ptr advances).
  - ramstate ERROR counts like BUSY.
- Without the macro: no counter; a grant waits indefinitely; arb_err tied 0.

Test Plan:
- CPUS=2, core0 iREN=1 iaddr=0x100, RAM ACCESS after 2 BUSY cycles -> ramREN=1 ramaddr=0x100 from cycle 1; iwait[0]=0 only in the ACCESS cycle; iload=ramload.
- Core0 dWEN=1 daddr=0x200 dstore=0xDEADBEEF and iREN=1 together -> D served first with ramWEN=1, ramREN=0; I served in a later grant.
- Both cores request continuously, each ACCESS after 1 cycle -> grants alternate 0,1,0,1; no core gets two consecutive grants.
- Core1 granted, drops dREN before ACCESS -> IDLE next cycle, no dwait release, rr_ptr stays 1 so core1 is rescanned first.
- nRST=0 during GRANT with ramWEN=1 -> next cycle ramWEN=0, all waits=1; first grant after reset goes to core0 when both request.
- MEM_ARB_TIMEOUT_EN, TIMEOUT=8, ramstate stuck BUSY -> arb_err=1 in grant cycle 8; next transaction goes to the other core.

Source files
------------

// File: rtl/mem_arbiter_rr.sv
// Round-robin arbiter of per-core instruction/data requests onto one shared RAM port.
// Optional grant timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter_rr #(
    parameter int CPUS    = 2,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [CPUS-1:0]    iREN,
    input  logic [CPUS-1:0]    dREN,
    input  logic [CPUS-1:0]    dWEN,
    input  logic [CPUS*AW-1:0] iaddr,
    input  logic [CPUS*AW-1:0] daddr,
    input  logic [CPUS*DW-1:0] dstore,
    output logic [CPUS-1:0]    iwait,
    output logic [CPUS-1:0]    dwait,
    output logic [DW-1:0]      iload,
    output logic [DW-1:0]      dload,
    output logic               ramREN,
    output logic               ramWEN,
    output logic [AW-1:0]      ramaddr,
    output logic [DW-1:0]      ramstore,
    input  logic [DW-1:0]      ramload,
    input  logic [1:0]         ramstate,
    output logic               arb_err
);
    // ramstate_t encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
    localparam logic [1:0] ACCESS = 2'd2;
    localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   rr_ptr, rr_ptr_n, gnt_cpu, gnt_cpu_n, pick;
    logic            gnt_is_d, gnt_is_d_n, pick_vld, g_act, to_hit;
    logic [CPUS-1:0] dreq, req;
    logic [AW-1:0]   g_iaddr, g_daddr;
    logic [DW-1:0]   g_store;
    int              idx;

    assign dreq  = dREN | dWEN;
    assign req   = dreq | iREN;
    assign iload = ramload;
    assign dload = ramload;

    assign g_iaddr = iaddr[int'(gnt_cpu)*AW +: AW];
    assign g_daddr = daddr[int'(gnt_cpu)*AW +: AW];
    assign g_store = dstore[int'(gnt_cpu)*DW +: DW];
    assign g_act   = gnt_is_d ? dreq[gnt_cpu] : iREN[gnt_cpu];

    // Scan from the highest offset down so the nearest requester to rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick     = rr_ptr;
        idx      = 0;
        for (int i = CPUS - 1; i >= 0; i--) begin
            idx = (int'(rr_ptr) + i) % CPUS;
            if (req[idx]) begin
                pick_vld = 1'b1;
                pick     = CW'(idx);
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [TW-1:0] cnt;

    assign to_hit  = (state == GRANT) && g_act && (ramstate != ACCESS) &&
                     (cnt == TW'(TIMEOUT - 1));
    assign arb_err = to_hit;

    // ERROR is not ACCESS, so it counts exactly like BUSY.
    always_ff @(posedge CLK) begin
        if (!nRST)                  cnt <= '0;
        else if (state != GRANT)    cnt <= '0;
        else if (ramstate != ACCESS) cnt <= cnt + 1'b1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = TIMEOUT;
    assign to_hit         = 1'b0;
    assign arb_err        = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        rr_ptr_n   = rr_ptr;
        gnt_cpu_n  = gnt_cpu;
        gnt_is_d_n = gnt_is_d;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = '1;
        dwait      = '1;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    gnt_cpu_n  = pick;
                    gnt_is_d_n = dreq[pick];
                    state_n    = GRANT;
                end
            end
            GRANT: begin
                ramaddr  = gnt_is_d ? g_daddr : g_iaddr;
                ramstore = g_store;
                if (!g_act) begin
                    state_n = IDLE;
                end else if (to_hit) begin
                    // Release the stalled core with invalid data; enables stay low.
                    if (gnt_is_d) dwait[gnt_cpu] = 1'b0;
                    else          iwait[gnt_cpu] = 1'b0;
                    state_n = DONE;
                end else begin
                    ramWEN = gnt_is_d & dWEN[gnt_cpu];
                    ramREN = gnt_is_d ? (dREN[gnt_cpu] & ~dWEN[gnt_cpu]) : iREN[gnt_cpu];
                    if (ramstate == ACCESS) begin
                        if (gnt_is_d) dwait[gnt_cpu] = 1'b0;
                        else          iwait[gnt_cpu] = 1'b0;
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                rr_ptr_n = CW'((int'(gnt_cpu) + 1) % CPUS);
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_cpu  <= '0;
            gnt_is_d <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_ptr_n;
            gnt_cpu  <= gnt_cpu_n;
            gnt_is_d <= gnt_is_d_n;
        end
    end
endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Directed bench for mem_arbiter_rr with CPUS=2; timeout steps run when MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_arbiter_rr;
    localparam int CPUS = 2, AW = 32, DW = 32, TIMEOUT = 8;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

    logic               CLK, nRST;
    logic [CPUS-1:0]    iREN, dREN, dWEN, iwait, dwait;
    logic [CPUS*AW-1:0] iaddr, daddr;
    logic [CPUS*DW-1:0] dstore;
    logic [DW-1:0]      iload, dload, ramstore, ramload;
    logic [AW-1:0]      ramaddr;
    logic               ramREN, ramWEN, arb_err;
    logic [1:0]         ramstate;
    int                 n_cmp = 0, n_bad = 0;

    mem_arbiter_rr #(.CPUS(CPUS), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .nRST(nRST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
        .iload(iload), .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN),
        .ramaddr(ramaddr), .ramstore(ramstore), .ramload(ramload),
        .ramstate(ramstate), .arb_err(arb_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 0; iREN = '0; dREN = '0; dWEN = '0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramstate = BUSY; ramload = 32'hCAFE0001;
        repeat (2) step();
        #1;
        chk("rst_ren", ramREN, 0);
        chk("rst_wen", ramWEN, 0);
        chk("rst_addr", ramaddr, 0);
        chk("rst_iwait", iwait, 2'b11);
        chk("rst_dwait", dwait, 2'b11);
        chk("rst_err", arb_err, 0);

        // single instruction read, two BUSY cycles then ACCESS
        nRST = 1; iREN = 2'b01;
        iaddr[31:0] = 32'h100; iaddr[63:32] = 32'h300;
        #1; chk("t1_idle_ren", ramREN, 0);
        step(); #1;
        chk("t1_ren", ramREN, 1);
        chk("t1_addr", ramaddr, 32'h100);
        chk("t1_busy1_iwait", iwait, 2'b11);
        step(); #1;
        chk("t1_busy2_iwait", iwait, 2'b11);
        ramstate = ACCESS; #1;
        chk("t1_ack_iwait", iwait, 2'b10);
        chk("t1_ack_dwait", dwait, 2'b11);
        chk("t1_iload", iload, 32'hCAFE0001);
        chk("t1_dload", dload, 32'hCAFE0001);
        step(); ramstate = FREE; iREN = 2'b00; #1;
        chk("t1_done_ren", ramREN, 0);
        chk("t1_done_iwait", iwait, 2'b11);
        step();

        // data write and instruction read on core0: data first
        dWEN = 2'b01; iREN = 2'b01;
        daddr[31:0] = 32'h200; daddr[63:32] = 32'h400; dstore[31:0] = 32'hDEADBEEF;
        step();
        ramstate = ACCESS; #1;
        chk("t2_wen", ramWEN, 1);
        chk("t2_ren", ramREN, 0);
        chk("t2_addr", ramaddr, 32'h200);
        chk("t2_store", ramstore, 32'hDEADBEEF);
        chk("t2_dwait", dwait, 2'b10);
        chk("t2_iwait", iwait, 2'b11);
        step(); dWEN = 2'b00; ramstate = FREE; #1;
        chk("t2_done_dwait", dwait, 2'b11);
        step(); #1;
        chk("t2_idle_ren", ramREN, 0);
        step(); ramstate = ACCESS; #1;
        chk("t2_i_addr", ramaddr, 32'h100);
        chk("t2_i_ren", ramREN, 1);
        chk("t2_i_wen", ramWEN, 0);
        chk("t2_i_iwait", iwait, 2'b10);
        step(); iREN = 2'b00; ramstate = FREE;
        step();

        // both cores continuously: rr_ptr is 1 here, so grants go 1,0,1,0
        iREN = 2'b11;
        for (int k = 0; k < 4; k++) begin
            ramstate = BUSY;
            step(); #1;
            chk("t3_addr", ramaddr, (k % 2 == 0) ? 32'h300 : 32'h100);
            chk("t3_busy_iwait", iwait, 2'b11);
            ramstate = ACCESS; #1;
            chk("t3_ack_iwait", iwait, (k % 2 == 0) ? 2'b01 : 2'b10);
            step(); ramstate = FREE; #1;
            chk("t3_done_iwait", iwait, 2'b11);
            step();
        end
        iREN = 2'b00;

        // core1 drops its data read before ACCESS: abort, rr_ptr stays 1
        dREN = 2'b10; ramstate = BUSY;
        step(); #1;
        chk("t4_addr", ramaddr, 32'h400);
        chk("t4_ren", ramREN, 1);
        dREN = 2'b00; #1;
        chk("t4_drop_dwait", dwait, 2'b11);
        chk("t4_drop_ren", ramREN, 0);
        step(); #1;
        chk("t4_idle_addr", ramaddr, 0);
        dREN = 2'b11; dWEN = 2'b10;
        step(); #1;
        chk("t4_rescan_addr", ramaddr, 32'h400);
        chk("t4_rescan_wen", ramWEN, 1);
        chk("t4_rescan_ren", ramREN, 0);

        // reset in the middle of a write grant
        nRST = 0;
        step(); #1;
        chk("t5_wen", ramWEN, 0);
        chk("t5_ren", ramREN, 0);
        chk("t5_dwait", dwait, 2'b11);
        chk("t5_iwait", iwait, 2'b11);
        nRST = 1; dWEN = 2'b00; dREN = 2'b11;
        step(); #1;
        chk("t5_first_addr", ramaddr, 32'h200);
        chk("t5_first_ren", ramREN, 1);
        ramstate = ACCESS; #1;
        chk("t5_first_dwait", dwait, 2'b10);
        step(); dREN = 2'b00; ramstate = FREE;
        step();

`ifdef MEM_ARB_TIMEOUT_EN
        // RAM stuck BUSY: timeout fires in grant cycle TIMEOUT
        iREN = 2'b01; ramstate = BUSY;
        step();
        for (int c = 1; c < TIMEOUT; c++) begin
            #1; chk("t6_no_err", arb_err, 0);
            step();
        end
        #1;
        chk("t6_err", arb_err, 1);
        chk("t6_ren", ramREN, 0);
        chk("t6_iwait", iwait, 2'b10);
        step(); iREN = 2'b11; #1;
        chk("t6_done_err", arb_err, 0);
        step();
        step(); #1;
        chk("t6_next_addr", ramaddr, 32'h300);
        iREN = 2'b00;
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
